axi_burst_mem_slave: RTL and testbench
======================================

Name: axi_burst_mem_slave

Overview:
- AXI4 burst responder (slave) backed by an internal single-port word memory.
- Pairs with the AXI burst traffic-generator master as its far end: accepts AW/W/B write bursts and AR/R read bursts, and returns written data on read-back.
- Used as a DDR stand-in for simulation and FPGA loopback tests of the master.
- Handles INCR bursts only, one transaction at a time.

Parameters:
- A_WIDTH, 26, byte-address width of awaddr/araddr.
- D_WIDTH, 16, data beat width in bits.
- D_LEVEL, 1, log2(bytes per beat); word index = addr[D_LEVEL +: MEM_AWIDTH].
- MEM_AWIDTH, 10, log2(memory depth in words); address bits above the index are ignored (aliasing).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- awaddr  in  A_WIDTH  write burst start byte address.
- awlen  in  8  write beats minus 1.
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
- wlast  in  1  master's last-beat marker.
- wdata  in  D_WIDTH  write data.
- bvalid  out  1  write response valid (OKAY implied).
- bready  in  1  write response ready.
- arvalid  in  1  read-address valid.
- arready  out  1  read-address ready.
- araddr  in  A_WIDTH  read burst start byte address.
- arlen  in  8  read beats minus 1.
- rvalid  out  1  read-data valid.
- rready  in  1  read-data ready.
- rlast  out  1  last read beat.
- rdata  out  D_WIDTH  read data.
- wlast_err  out  1  sticky: wlast disagreed with the awlen-derived beat count.

Behaviour:
- Reset (rst high at a clk edge): state IDLE; awready=arready=wready=bvalid=rvalid=rlast=0; rdata=0; wlast_err=0; beat counter=0; priority pointer=write. Memory contents are not cleared. Reset mid-burst abandons the burst immediately.
- States: IDLE, WDATA, WRESP, RPRE, RDATA.
- IDLE:
  - awready = 1 only if awvalid is high and write has priority, or awvalid is high and arvalid is low; arready is handled symmetrically.
  - At most one of awready/arready is high in any cycle.
  - When both are valid, the channel not served last wins (round-robin); after reset, write wins.
  - AW handshake: latch word index and len, clear cnt, go to WDATA.
  - AR handshake: latch index and len, clear cnt, go to RPRE.
- WDATA:
  - wready=1.
  - Each wvalid&&wready: mem[idx] <= wdata; idx <= idx+1 (wraps modulo 2^MEM_AWIDTH); cnt++.
  - If wlast != (cnt==len), set wlast_err (sticky until rst).
  - When the beat with cnt==len is accepted, go to WRESP, regardless of wlast.
- WRESP:
  - bvalid=1; hold until bready.
  - On the handshake, return to IDLE; the next IDLE cycle may accept a new address.
- RPRE:
  - One cycle; register mem[idx] into rdata; go to RDATA.
  - First rvalid comes 2 cycles after the AR handshake edge.
- RDATA:
  - rvalid=1; rlast = (cnt==len).
  - rdata is stable while rvalid && !rready.
  - On handshake with cnt<len: idx++, cnt++, rdata <= mem[idx+1] in the same edge, so back-to-back beats run with no bubbles.
  - On handshake with rlast: return to IDLE.
- Read-after-write: a read issued after B completes returns the written data. No hazard exists because transactions are serialized.
- len=0 gives single-beat bursts. len=255 gives 256 beats; the 8-bit counter must not overflow before the compare.
- awvalid/arvalid seen during a non-IDLE state are ignored until IDLE; the master holds them per AXI rules.

Optional Feature:
- Macro AXI_SLV_BACKPRESSURE_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) advances every clk.
  - awready, arready, wready and bvalid are additionally gated by lfsr[0].
  - Entry into RDATA and each next beat are delayed while lfsr[1]=0, by inserting cycles with rvalid low.
  - Once bvalid or rvalid is asserted it holds until the handshake, per AXI.
- Undefined: no gating; the timing above is exact.

Test Plan:
- Write idx 0, awlen=7, wdata=0,2,4..14, then read araddr=0 arlen=7 -> rdata 0,2,..,14; rlast only on beat 8; bvalid once; wlast_err=0.
- AR handshake at cycle T, rready=1 -> rvalid first high at T+2; 8 consecutive beats, no gaps.
- awvalid and arvalid high in the same IDLE cycle after reset -> write served first, then read; next simultaneous request -> read served first.
- Write awlen=3 with wlast on beat 2 -> wlast_err=1 and stays 1; all 4 beats written; B after beat 4.
- MEM_AWIDTH=4, write at word 14, awlen=3 -> words 14,15,0,1 written; read-back matches.
- rst asserted mid-RDATA -> next cycle rvalid=0, state IDLE; a new AR is accepted normally.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR-only burst slave backed by a single-port word memory.
// Serves one transaction at a time: AW/W/B writes and AR/R reads, with
// round-robin arbitration between the write and read address channels.
// Optional macro AXI_SLV_BACKPRESSURE_EN adds LFSR-driven random stalls
// on the ready/valid handshakes.
module axi_burst_mem_slave #(
  parameter int A_WIDTH    = 26,
  parameter int D_WIDTH    = 16,
  parameter int D_LEVEL    = 1,
  parameter int MEM_AWIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [A_WIDTH-1:0] awaddr,
  input  logic [7:0]         awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic               wlast,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               bvalid,
  input  logic               bready,
  input  logic               arvalid,
  output logic               arready,
  input  logic [A_WIDTH-1:0] araddr,
  input  logic [7:0]         arlen,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic [D_WIDTH-1:0] rdata,
  output logic               wlast_err
);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RPRE, RDATA} state_t;

  state_t                state, state_nxt;
  logic [MEM_AWIDTH-1:0] idx, idx_inc, rd_addr;
  logic [7:0]            len, cnt;
  logic                  wr_prio;   // 1: write channel wins a tie
  logic                  mem_we, rd_load;
  logic                  rdy_gate, b_ok, r_ok;
  logic [D_WIDTH-1:0]    mem [0:(1<<MEM_AWIDTH)-1];

  // Address bits outside the word index are ignored (the memory aliases).
  logic unused_addr;
  assign unused_addr = ^{awaddr, araddr};

  assign idx_inc = idx + MEM_AWIDTH'(1);

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        b_hold, r_hold;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR supplying the stall pattern.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Remember an unaccepted bvalid/rvalid so it cannot drop before its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_hold <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      b_hold <= bvalid & ~bready;
      r_hold <= rvalid & ~rready;
    end
  end

  assign rdy_gate = lfsr[0];
  assign b_ok     = lfsr[0] | b_hold;
  assign r_ok     = lfsr[1] | r_hold;
`else
  assign rdy_gate = 1'b1;
  assign b_ok     = 1'b1;
  assign r_ok     = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake outputs and memory strobes.
  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    rd_addr   = idx;
    case (state)
      IDLE: begin
        awready = !rst && rdy_gate && awvalid && (wr_prio || !arvalid);
        arready = !rst && rdy_gate && arvalid && (!wr_prio || !awvalid);
        if (awready)      state_nxt = WDATA;
        else if (arready) state_nxt = RPRE;
      end
      WDATA: begin
        wready = rdy_gate;
        if (wvalid && wready) begin
          mem_we = 1'b1;
          if (cnt == len) state_nxt = WRESP;
        end
      end
      WRESP: begin
        bvalid = b_ok;
        if (bvalid && bready) state_nxt = IDLE;
      end
      RPRE: begin
        rd_load   = 1'b1;
        state_nxt = RDATA;
      end
      RDATA: begin
        rvalid = r_ok;
        rlast  = r_ok && (cnt == len);
        if (rvalid && rready) begin
          if (cnt == len) begin
            state_nxt = IDLE;
          end else begin
            // Prefetch the next word on the same edge so beats run gap-free.
            rd_load = 1'b1;
            rd_addr = idx_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: word index, beat count, arbitration pointer, read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      len       <= '0;
      cnt       <= '0;
      wr_prio   <= 1'b1;
      rdata     <= '0;
      wlast_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            idx     <= awaddr[D_LEVEL +: MEM_AWIDTH];
            len     <= awlen;
            cnt     <= '0;
            wr_prio <= 1'b0;
          end else if (arready) begin
            idx     <= araddr[D_LEVEL +: MEM_AWIDTH];
            len     <= arlen;
            cnt     <= '0;
            wr_prio <= 1'b1;
          end
        end
        WDATA: begin
          if (wvalid && wready) begin
            idx <= idx_inc;
            cnt <= cnt + 8'd1;
            if (wlast != (cnt == len)) wlast_err <= 1'b1;
          end
        end
        RDATA: begin
          if (rvalid && rready && cnt != len) begin
            idx <= idx_inc;
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
      if (rd_load) rdata <= mem[rd_addr];
    end
  end

  // Word memory; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Self-checking bench for axi_burst_mem_slave (default build, no backpressure).
// A model memory tracks writes; reads push expected beats to a queue that is
// popped as the DUT returns data.
module tb_axi_burst_mem_slave;
  localparam int AW = 26, DW = 16, MA = 10, DEPTH = 1 << MA;

  logic          clk = 1'b0, rst = 1'b1;
  logic          awvalid = 0, awready, wvalid = 0, wready, wlast = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic          bvalid, bready = 0, arvalid = 0, arready;
  logic          rvalid, rready = 0, rlast, wlast_err;

  int            checks = 0, errors = 0;
  logic [DW-1:0] model [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  logic          exp_werr = 1'b0;

  axi_burst_mem_slave #(.A_WIDTH(AW), .D_WIDTH(DW), .D_LEVEL(1), .MEM_AWIDTH(MA)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input int len);
    logic [MA-1:0] i0;
    i0 = a[1 +: MA];
    for (int b = 0; b <= len; b++) exp_q.push_back(model[i0 + MA'(b)]);
  endtask

  task automatic aw_req(input logic [AW-1:0] a, input int len);
    int n = 0;
    awvalid = 1; awaddr = a; awlen = len[7:0]; #1;
    while (!awready && n < 64) begin tick(); n++; end
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL aw_handshake: awready=%b want 1", awready); end
    tick(); awvalid = 0;
  endtask

  task automatic ar_req(input logic [AW-1:0] a, input int len);
    int n = 0;
    arvalid = 1; araddr = a; arlen = len[7:0]; #1;
    while (!arready && n < 64) begin tick(); n++; end
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL ar_handshake: arready=%b want 1", arready); end
    push_exp(a, len);
    tick(); arvalid = 0;
  endtask

  task automatic send_w(input logic [MA-1:0] i0, input int len, input int wl_beat,
                        input bit rnd, input logic [DW-1:0] base);
    for (int b = 0; b <= len; b++) begin
      logic [DW-1:0] d;
      int n;
      n = 0;
      d = rnd ? DW'($urandom) : base + DW'(2 * b);
      wvalid = 1; wdata = d; wlast = (b == wl_beat); #1;
      while (!wready && n < 64) begin tick(); n++; end
      checks++;
      if (wready !== 1'b1 || bvalid !== 1'b0) begin
        errors++; $display("FAIL w_beat %0d: wready=%b bvalid=%b want 1/0", b, wready, bvalid);
      end
      model[i0 + MA'(b)] = d;
      tick();
    end
    wvalid = 0; wlast = 0;
    if (wl_beat != len) exp_werr = 1'b1;
  endtask

  task automatic get_b;
    int n = 0;
    bready = 1; #1;
    while (!bvalid && n < 64) begin tick(); n++; end
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL b_resp: bvalid=%b want 1", bvalid); end
    tick(); bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_once: bvalid=%b want 0", bvalid); end
    checks++;
    if (wlast_err !== exp_werr) begin errors++; $display("FAIL wlast_err: got %b want %b", wlast_err, exp_werr); end
  endtask

  task automatic get_r(input int len, input int stall_beat);
    logic [DW-1:0] e, hold;
    rready = 1;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL r_latency_rpre: rvalid=%b want 0", rvalid); end
    tick();
    for (int b = 0; b <= len; b++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL r_gap beat %0d: rvalid=%b want 1", b, rvalid); end
      checks++;
      if (rdata !== e) begin errors++; $display("FAIL r_data beat %0d: got %h want %h", b, rdata, e); end
      checks++;
      if (rlast !== (b == len)) begin errors++; $display("FAIL r_last beat %0d: got %b want %b", b, rlast, (b == len)); end
      if (b == stall_beat) begin
        hold = rdata; rready = 0; tick();
        checks++;
        if (rvalid !== 1'b1 || rdata !== hold) begin
          errors++; $display("FAIL r_stall_hold: rvalid=%b rdata=%h want 1/%h", rvalid, rdata, hold);
        end
        rready = 1;
      end
      tick();
    end
    rready = 0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL r_end: rvalid=%b want 0", rvalid); end
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int len, input int wl_beat,
                          input bit rnd, input logic [DW-1:0] base);
    aw_req(a, len);
    send_w(a[1 +: MA], len, wl_beat, rnd, base);
    get_b();
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int len, input int stall_beat);
    ar_req(a, len);
    get_r(len, stall_beat);
  endtask

  task automatic test_reset;
    rst = 1; tick(); tick();
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, wlast_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
                         {awready, arready, wready, bvalid, rvalid, rlast, wlast_err});
    end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst = 0; tick();
  endtask

  task automatic test_arbiter;
    // Both channels request together right after reset: write must win.
    awvalid = 1; awaddr = 26'h40; awlen = 0;
    arvalid = 1; araddr = 26'h40; arlen = 0; #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      errors++; $display("FAIL arb_first: aw/ar ready=%b%b want 10", awready, arready);
    end
    tick(); awvalid = 0;
    send_w(MA'(32), 0, 0, 0, 16'hA5A0);
    get_b();
    // New write alongside the held read: read was not served last, so it wins.
    awvalid = 1; awaddr = 26'h42; awlen = 0; #1;
    checks++;
    if (awready !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL arb_second: aw/ar ready=%b%b want 01", awready, arready);
    end
    push_exp(26'h40, 0);
    tick(); arvalid = 0;
    get_r(0, -1);
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL arb_third: awready=%b want 1", awready); end
    tick(); awvalid = 0;
    send_w(MA'(33), 0, 0, 0, 16'h5A50);
    get_b();
    rd_burst(26'h40, 1, -1);
  endtask

  task automatic test_basic;
    wr_burst(26'h0, 7, 7, 0, 16'h0);
    rd_burst(26'h0, 7, -1);
  endtask

  task automatic test_back_to_back;
    rd_burst(26'h0, 7, 3);
    rd_burst(26'h4, 2, 0);
  endtask

  task automatic test_len_edges;
    wr_burst(26'h100, 0, 0, 1, 16'h0);
    rd_burst(26'h100, 0, -1);
    wr_burst(26'h200, 255, 255, 1, 16'h0);
    rd_burst(26'h200, 255, -1);
  endtask

  task automatic test_wrap;
    wr_burst(26'h7FC, 3, 3, 1, 16'h0);           // words 1022,1023,0,1
    rd_burst(26'h10007FC, 3, -1);                 // high address bits alias
    rd_burst(26'h0, 1, -1);
  endtask

  task automatic test_wlast_err;
    wr_burst(26'h300, 3, 1, 1, 16'h0);            // wlast early on beat 2
    rd_burst(26'h300, 3, -1);
    wr_burst(26'h310, 1, 1, 1, 16'h0);            // clean burst, flag stays set
  endtask

  task automatic test_reset_mid_read;
    ar_req(26'h0, 7);
    rready = 1;
    tick(); tick(); tick();                        // two beats accepted, third on the bus
    rst = 1; tick(); rst = 0;
    checks++;
    if ({rvalid, rlast, wlast_err} !== 3'b0 || rdata !== '0) begin
      errors++; $display("FAIL reset_mid_read: rvalid/rlast/werr=%b rdata=%h want 000/0",
                         {rvalid, rlast, wlast_err}, rdata);
    end
    rready = 0;
    exp_q.delete();
    exp_werr = 1'b0;
    tick();
    rd_burst(26'h0, 7, -1);
    wr_burst(26'h20, 2, 2, 1, 16'h0);
    rd_burst(26'h20, 2, -1);
  endtask

  initial begin
    test_reset();
    test_arbiter();
    test_basic();
    test_back_to_back();
    test_len_edges();
    test_wrap();
    test_wlast_err();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
